wb_unit: RTL and testbench

WB_UNIT -- requirements
Module: wb_unit

---
 rtl/wb_unit.sv | 125 ++++++++++++
 tb/tb_wb_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/wb_unit.sv
// wb_unit: writeback stage with ALU results, one outstanding load, and rd-0 write suppression.
// Optional WB_UNIT_FWD_EN mirrors the register-file write port onto fwd_*.
module wb_unit #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_load,
  input  logic [2:0]            in_funct3,
  output logic                  mem_req,
  output logic [DATA_WIDTH-1:0] mem_addr,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] pend_rd,
  output logic                  ld_err,
  output logic                  fwd_valid,
  output logic [ADDR_WIDTH-1:0] fwd_rd,
  output logic [DATA_WIDTH-1:0] fwd_data
);
  typedef enum logic [1:0] {IDLE, MEM_WAIT, WRITE} state_t;
  state_t state, state_d;
  logic [ADDR_WIDTH-1:0] rd_q, rd_d, waddr_d;
  logic [2:0] f3_q, f3_d;
  logic [1:0] lo_q, lo_d;
  logic wen_d, req_d, err_d, accept, bad;
  logic [DATA_WIDTH-1:0] wdata_d, addr_d, ld_data;
  logic [7:0] b;
  logic [15:0] h;
  assign in_ready = state != MEM_WAIT;
  assign accept = in_valid && in_ready;
  assign busy = state != IDLE;
  assign pend_rd = busy ? rd_q : '0;
  assign bad = in_funct3 == 3'b011 || in_funct3[2:1] == 2'b11 ||
               (in_funct3[1:0] == 2'b01 && in_data[0]) ||
               (in_funct3 == 3'b010 && in_data[1:0] != 2'b00);
  // Only legal funct3 values are held, so bit 1 alone marks LW and bit 2 marks unsigned.
  assign b = mem_rdata[{lo_q, 3'b000} +: 8];
  assign h = lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  assign ld_data = f3_q[1] ? mem_rdata :
                   f3_q[0] ? {{16{~f3_q[2] & h[15]}}, h} : {{24{~f3_q[2] & b[7]}}, b};
  always_comb begin
    state_d = state;
    rd_d = rd_q;
    f3_d = f3_q;
    lo_d = lo_q;
    wen_d = 1'b0;
    waddr_d = '0;
    wdata_d = '0;
    req_d = 1'b0;
    addr_d = '0;
    err_d = 1'b0;
    if (state == MEM_WAIT) begin
      req_d = !mem_rvalid;
      addr_d = mem_rvalid ? '0 : mem_addr;
      if (mem_rvalid) begin
        state_d = WRITE;
        wen_d = rd_q != '0;
        waddr_d = rd_q;
        wdata_d = ld_data;
      end
    end else begin
      state_d = IDLE;
      if (accept) begin
        rd_d = in_rd;
        f3_d = in_funct3;
        lo_d = in_data[1:0];
        if (!in_load) begin
          state_d = WRITE;
          wen_d = in_rd != '0;
          waddr_d = in_rd;
          wdata_d = in_data;
        end else if (bad) begin
          err_d = 1'b1;
        end else begin
          state_d = MEM_WAIT;
          req_d = 1'b1;
          addr_d = {in_data[DATA_WIDTH-1:2], 2'b00};
        end
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rd_q <= '0;
      f3_q <= '0;
      lo_q <= '0;
      rf_wen <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      mem_req <= 1'b0;
      mem_addr <= '0;
      ld_err <= 1'b0;
    end else begin
      state <= state_d;
      rd_q <= rd_d;
      f3_q <= f3_d;
      lo_q <= lo_d;
      rf_wen <= wen_d;
      rf_waddr <= waddr_d;
      rf_wdata <= wdata_d;
      mem_req <= req_d;
      mem_addr <= addr_d;
      ld_err <= err_d;
    end
  end
`ifdef WB_UNIT_FWD_EN
  assign fwd_valid = rf_wen;
  assign fwd_rd = rf_waddr;
  assign fwd_data = rf_wdata;
`else
  assign fwd_valid = 1'b0;
  assign fwd_rd = '0;
  assign fwd_data = '0;
`endif
endmodule

// File: tb/tb_wb_unit.sv
// tb_wb_unit: directed and randomized checks of wb_unit against a behavioural load/write model.
module tb_wb_unit;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_load = 1'b0, mem_rvalid = 1'b0;
  logic in_ready, mem_req, rf_wen, busy, ld_err, fwd_valid;
  logic [4:0] in_rd = '0, rf_waddr, pend_rd, fwd_rd;
  logic [2:0] in_funct3 = '0;
  logic [31:0] in_data = '0, mem_rdata = '0, mem_addr, rf_wdata, fwd_data;
  int checks = 0, errors = 0;

  wb_unit dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd),
    .in_data(in_data), .in_load(in_load), .in_funct3(in_funct3), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .rf_wen(rf_wen),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy(busy), .pend_rd(pend_rd), .ld_err(ld_err),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit ld_legal(input int f3, input logic [31:0] a);
    if (f3 == 0 || f3 == 4) return 1'b1;
    if (f3 == 1 || f3 == 5) return (a % 2) == 0;
    if (f3 == 2) return (a % 4) == 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ld_ref(input int f3, input logic [31:0] a, input logic [31:0] w);
    longint v;
    if (f3 == 2) return w;
    if (f3 == 0 || f3 == 4) begin
      v = longint'((w >> (8 * (a % 4))) % 256);
      if (f3 == 0 && v >= 128) v = v - 256;
    end else begin
      v = longint'((w >> (16 * ((a % 4) / 2))) % 65536);
      if (f3 == 1 && v >= 32768) v = v - 65536;
    end
    return 32'(v);
  endfunction

  always @(negedge clk) begin
`ifdef WB_UNIT_FWD_EN
    check("fwd_valid", fwd_valid, rf_wen);
    check("fwd_rd", fwd_rd, rf_waddr);
    check("fwd_data", fwd_data, rf_wdata);
`else
    check("fwd_valid_off", fwd_valid, 0);
`endif
  end

  task automatic alu(input logic [4:0] rd, input logic [31:0] d);
    @(negedge clk);
    in_valid = 1'b1; in_load = 1'b0; in_rd = rd; in_data = d; in_funct3 = 3'($urandom);
    @(negedge clk);
    in_valid = 1'b0;
    check("alu_wen", rf_wen, rd != 0);
    check("alu_busy", busy, 1);
    if (rd != 0) begin
      check("alu_waddr", rf_waddr, rd);
      check("alu_wdata", rf_wdata, d);
    end
    @(negedge clk);
    check("alu_wen_off", rf_wen, 0);
    check("alu_idle", busy, 0);
  endtask

  task automatic load(input int f3, input logic [31:0] a, input logic [4:0] rd,
                      input logic [31:0] w, input int waits, input logic [31:0] exp);
    bit ok = ld_legal(f3, a);
    @(negedge clk);
    in_valid = 1'b1; in_load = 1'b1; in_funct3 = 3'(f3); in_data = a; in_rd = rd;
    @(negedge clk);
    in_valid = 1'b0; in_load = 1'b0;
    if (!ok) begin
      check("err_pulse", ld_err, 1);
      check("err_req", mem_req, 0);
      check("err_wen", rf_wen, 0);
      check("err_busy", busy, 0);
      @(negedge clk);
      check("err_off", ld_err, 0);
      check("err_wen2", rf_wen, 0);
    end else begin
      check("ld_req", mem_req, 1);
      check("ld_addr", mem_addr, a & 32'hFFFF_FFFC);
      check("ld_ready", in_ready, 0);
      check("ld_pend", pend_rd, rd);
      check("ld_err0", ld_err, 0);
      repeat (waits - 1) begin
        @(negedge clk);
        check("ld_hold", mem_req, 1);
        check("ld_hold_wen", rf_wen, 0);
      end
      mem_rvalid = 1'b1; mem_rdata = w;
      @(negedge clk);
      mem_rvalid = 1'b0; mem_rdata = $urandom;
      check("ld_req_off", mem_req, 0);
      check("ld_wen", rf_wen, rd != 0);
      if (rd != 0) begin
        check("ld_waddr", rf_waddr, rd);
        check("ld_wdata", rf_wdata, exp);
      end
      @(negedge clk);
      check("ld_wen_off", rf_wen, 0);
      check("ld_idle", busy, 0);
      check("ld_pend_idle", pend_rd, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    #1;
    check("rst_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_req", mem_req, 0);
    check("rst_wen", rf_wen, 0);
    check("rst_err", ld_err, 0);
    check("rst_pend", pend_rd, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    alu(5'd5, 32'h1234_5678);
    load(0, 32'h8000_0003, 5'd9, 32'h80FF_FFFF, 3, 32'hFFFF_FF80);
    load(4, 32'h8000_0003, 5'd9, 32'h80FF_FFFF, 3, 32'h0000_0080);
    load(1, 32'h8000_0001, 5'd4, 32'h0, 1, 32'h0);
    load(5, 32'h8000_0002, 5'd4, 32'hBEEF_0000, 2, 32'h0000_BEEF);
    load(2, 32'h8000_0006, 5'd4, 32'h0, 1, 32'h0);
    load(3, 32'h8000_0000, 5'd4, 32'h0, 1, 32'h0);
    alu(5'd0, 32'hDEAD_BEEF);
    @(negedge clk);
    in_valid = 1'b1; in_load = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      in_rd = 5'(i); in_data = 32'(i * 32'h1111_0000);
      @(negedge clk);
      check("b2b_wen", rf_wen, 1);
      check("b2b_waddr", rf_waddr, i);
      check("b2b_wdata", rf_wdata, i * 32'h1111_0000);
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("b2b_off", rf_wen, 0);
    @(negedge clk);
    in_valid = 1'b1; in_load = 1'b1; in_funct3 = 3'b010; in_data = 32'h100; in_rd = 5'd7;
    @(negedge clk);
    in_valid = 1'b0; in_load = 1'b0;
    check("rstw_req", mem_req, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rstw_req_drop", mem_req, 0);
    check("rstw_busy_drop", busy, 0);
    check("rstw_ready", in_ready, 1);
    check("rstw_pend", pend_rd, 0);
    @(negedge clk);
    rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("late_wen", rf_wen, 0);
    check("late_busy", busy, 0);
    @(negedge clk);
    check("late_wen2", rf_wen, 0);
    for (int n = 0; n < 80; n++) begin
      int f3, waits;
      logic [31:0] a, w;
      logic [4:0] rd;
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = $urandom;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("stray_wen", rf_wen, 0);
        check("stray_busy", busy, 0);
      end
      rd = 5'($urandom);
      a = $urandom;
      w = $urandom;
      if ($urandom_range(0, 2) == 0) alu(rd, a);
      else begin
        f3 = $urandom_range(0, 7);
        waits = $urandom_range(1, 4);
        load(f3, a, rd, w, waits, ld_ref(f3, a, w));
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
